// File: rtl/rmt_steer.sv
// Header-matching AXI-Stream steering stage: forwards frames whose beat 0 carries the expected
// EtherType/delimiter (tdest from a programmable function table) and drops the rest whole.
// Optional frame counters are enabled by defining RMT_STEER_STATS_EN.
module rmt_steer #(
  parameter int                    DATA_WIDTH   = 512,
  parameter int                    KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int                    USER_WIDTH   = 1,
  parameter int                    DEST_WIDTH   = 2,
  parameter int                    TABLE_DEPTH  = 4,
  parameter logic [15:0]           ETHER_TYPE   = 16'h0008,
  parameter int                    ETHER_OFFSET = 12,
  parameter logic [15:0]           DELIM_VALUE  = 16'hF0E1,
  parameter int                    DELIM_OFFSET = 42,
  parameter int                    FUNC_OFFSET  = 44,
  parameter logic [DEST_WIDTH-1:0] DEFAULT_DEST = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [USER_WIDTH-1:0]          s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic [DEST_WIDTH-1:0]          m_axis_tdest,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(TABLE_DEPTH)-1:0] cfg_wr_index,
  input  logic                           cfg_wr_valid,
  input  logic [15:0]                    cfg_wr_func,
  input  logic [DEST_WIDTH-1:0]          cfg_wr_dest,
  output logic [31:0]                    stat_pass_frames,
  output logic [31:0]                    stat_drop_frames
);

  // Handshake: a beat moves on either side when tvalid && tready at a rising clk edge.
  // s_axis_tready is a flop and never looks at s_axis_tvalid; m_axis_* hold while stalled.

  typedef enum logic [1:0] {IDLE, TRANSFER, DROP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic [DEST_WIDTH-1:0] dest;
  } beat_t;

  state_t                state, state_next;
  logic                  beat_acc;
  logic                  hdr_match;
  logic                  push;
  logic [DEST_WIDTH-1:0] push_dest;
  logic [DEST_WIDTH-1:0] lut_dest;
  logic [DEST_WIDTH-1:0] cur_dest;
  logic [15:0]           ether_f, delim_f, func_f;

  logic                  tbl_valid [TABLE_DEPTH];
  logic [15:0]           tbl_func  [TABLE_DEPTH];
  logic [DEST_WIDTH-1:0] tbl_dest  [TABLE_DEPTH];

  beat_t                 in_beat, out_q, skid_q;
  logic                  out_valid, skid_valid, skid_valid_next;
  logic                  out_free;
  logic                  ready_q;

  assign ether_f   = s_axis_tdata[ETHER_OFFSET*8 +: 16];
  assign delim_f   = s_axis_tdata[DELIM_OFFSET*8 +: 16];
  assign func_f    = s_axis_tdata[FUNC_OFFSET*8 +: 16];
  assign hdr_match = (ether_f == ETHER_TYPE) && (delim_f == DELIM_VALUE);
  assign beat_acc  = s_axis_tvalid && s_axis_tready;

  // Walk from the top index down so the lowest matching entry is the one left standing.
  always_comb begin
    lut_dest = DEFAULT_DEST;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (tbl_valid[i] && (tbl_func[i] == func_f)) lut_dest = tbl_dest[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_func[i]  <= '0;
        tbl_dest[i]  <= '0;
      end
    end else if (cfg_wr_en) begin
      tbl_valid[cfg_wr_index] <= cfg_wr_valid;
      tbl_func[cfg_wr_index]  <= cfg_wr_func;
      tbl_dest[cfg_wr_index]  <= cfg_wr_dest;
    end
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    push_dest  = cur_dest;
    case (state)
      IDLE: begin
        if (beat_acc) begin
          if (hdr_match) begin
            push      = 1'b1;
            push_dest = lut_dest;
            if (!s_axis_tlast) state_next = TRANSFER;
          end else if (!s_axis_tlast) begin
            state_next = DROP;
          end
        end
      end
      TRANSFER: begin
        if (beat_acc) begin
          push = 1'b1;
          if (s_axis_tlast) state_next = IDLE;
        end
      end
      DROP: begin
        if (beat_acc && s_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_dest <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && beat_acc && hdr_match) cur_dest <= lut_dest;
    end
  end

  assign in_beat  = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, push_dest};
  assign out_free = !out_valid || m_axis_tready;

  // Upstream only sees ready while the skid slot is free, so a push never meets a full skid.
  assign skid_valid_next = out_free ? 1'b0 : (skid_valid || push);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      out_valid  <= 1'b0;
      skid_q     <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      ready_q    <= (state_next == DROP) || !skid_valid_next;
      skid_valid <= skid_valid_next;
      if (out_free) begin
        if (skid_valid) begin
          out_q     <= skid_q;
          out_valid <= 1'b1;
        end else if (push) begin
          out_q     <= in_beat;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (push) begin
        skid_q <= in_beat;
      end
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tdest  = out_q.dest;

`ifdef RMT_STEER_STATS_EN
  logic        pass_done, drop_done;
  logic [31:0] pass_cnt, drop_cnt;

  assign pass_done = beat_acc && s_axis_tlast &&
                     (((state == IDLE) && hdr_match) || (state == TRANSFER));
  assign drop_done = beat_acc && s_axis_tlast &&
                     (((state == IDLE) && !hdr_match) || (state == DROP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pass_done) pass_cnt <= pass_cnt + 32'd1;
      if (drop_done) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign stat_pass_frames = pass_cnt;
  assign stat_drop_frames = drop_cnt;
`else
  assign stat_pass_frames = '0;
  assign stat_drop_frames = '0;
`endif

endmodule

// File: tb/tb_rmt_steer.sv
// Bench for rmt_steer: directed vector table plus randomized frames checked against a
// frame-level reference model and an expected-beat queue.
module tb_rmt_steer;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int BW = DW + KW + 1 + 1 + 2;
`ifdef RMT_STEER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [0:0]    s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [0:0]    m_axis_tuser;
  logic [1:0]    m_axis_tdest;
  logic          cfg_wr_en, cfg_wr_valid;
  logic [1:0]    cfg_wr_index, cfg_wr_dest;
  logic [15:0]   cfg_wr_func;
  logic [31:0]   stat_pass_frames, stat_drop_frames;

  rmt_steer dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tdest(m_axis_tdest),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_index(cfg_wr_index), .cfg_wr_valid(cfg_wr_valid),
    .cfg_wr_func(cfg_wr_func), .cfg_wr_dest(cfg_wr_dest),
    .stat_pass_frames(stat_pass_frames), .stat_drop_frames(stat_drop_frames)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [BW-1:0] exp_q[$];
  int   obs_beats;
  logic [1:0] obs_dest;
  int   tready_bad = 0;
  int   since_rst  = 0;
  int   rdy_mode   = 0;

  // Reference model: frame-level view of the steering rules.
  bit          mdl_in_frame, mdl_fwd;
  logic [1:0]  mdl_dest;
  int          mdl_pass, mdl_drop;
  bit          mt_valid [4];
  logic [15:0] mt_func  [4];
  logic [1:0]  mt_dest  [4];

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [31:0] exp_stat(input int v);
    return STATS_ON ? 32'(v) : 32'd0;
  endfunction

  function automatic logic [15:0] wire_field(input logic [DW-1:0] d, input int off);
    return {d[(off+1)*8 +: 8], d[off*8 +: 8]};
  endfunction

  function automatic logic [1:0] mdl_lookup(input logic [15:0] fn);
    for (int i = 0; i < 4; i++)
      if (mt_valid[i] && mt_func[i] == fn) return mt_dest[i];
    return 2'd0;
  endfunction

  task automatic mdl_reset();
    exp_q.delete();
    mdl_in_frame = 0; mdl_fwd = 0; mdl_dest = 0; mdl_pass = 0; mdl_drop = 0;
    for (int i = 0; i < 4; i++) begin mt_valid[i] = 0; mt_func[i] = 0; mt_dest[i] = 0; end
  endtask

  task automatic mdl_beat();
    if (!mdl_in_frame) begin
      mdl_fwd  = (wire_field(s_axis_tdata, 12) == 16'h0008) &&
                 (wire_field(s_axis_tdata, 42) == 16'hF0E1);
      mdl_dest = mdl_lookup(wire_field(s_axis_tdata, 44));
    end
    if (mdl_fwd) exp_q.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, mdl_dest});
    if (s_axis_tlast) begin
      if (mdl_fwd) mdl_pass++; else mdl_drop++;
      mdl_in_frame = 0;
    end else begin
      mdl_in_frame = 1;
    end
  endtask

  // Monitor samples at the falling edge, where every DUT output and driven input is settled.
  task automatic monitor();
    logic [BW-1:0] got, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mdl_reset();
        since_rst = 0;
      end else begin
        since_rst++;
        if (m_axis_tvalid && m_axis_tready) begin
          obs_beats++;
          obs_dest = m_axis_tdest;
          got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest};
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1'b0, {got[BW-1 -: 60], got[3:0]}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_beat", got === e, {got[BW-1 -: 60], got[3:0]}, {e[BW-1 -: 60], e[3:0]});
          end
        end
        if (s_axis_tvalid && s_axis_tready) mdl_beat();
        if (cfg_wr_en) begin
          mt_valid[cfg_wr_index] = cfg_wr_valid;
          mt_func[cfg_wr_index]  = cfg_wr_func;
          mt_dest[cfg_wr_index]  = cfg_wr_dest;
        end
        if (since_rst > 1 && !s_axis_tready && !m_axis_tvalid) tready_bad++;
      end
    end
  endtask

  task automatic ready_driver();
    int cyc = 0;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = pat[cyc % 4];
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
      cyc++;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [DW-1:0] hdr_beat(input logic [15:0] eth, input logic [15:0] dl,
                                             input logic [15:0] fn);
    logic [DW-1:0] d;
    d = rand_data();
    d[12*8 +: 8] = eth[7:0]; d[13*8 +: 8] = eth[15:8];
    d[42*8 +: 8] = dl[7:0];  d[43*8 +: 8] = dl[15:8];
    d[44*8 +: 8] = fn[7:0];  d[45*8 +: 8] = fn[15:8];
    return d;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last,
                           output int waits);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = last;
    s_axis_tuser  = 1'($urandom_range(0, 1));
    s_axis_tvalid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      waits++;
      if (waits > 500) begin
        check("send_timeout", 1'b0, 64'(waits), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] eth, input logic [15:0] dl, input logic [15:0] fn,
                            input int n, output int waits);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    int w;
    waits = 0;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? hdr_beat(eth, dl, fn) : rand_data();
      k = (i == n - 1) ? {$urandom(), $urandom()} : '1;
      send_beat(d, k, i == n - 1, w);
      waits += w;
    end
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic v, input logic [15:0] fn,
                           input logic [1:0] dst);
    cfg_wr_index = idx; cfg_wr_valid = v; cfg_wr_func = fn; cfg_wr_dest = dst;
    cfg_wr_en = 1'b1;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", t < 300, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] ether;
    logic [15:0] delim;
    logic [15:0] func;
    int          nbeats;
    bit          exp_fwd;
    logic [1:0]  exp_dest;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [DW-1:0] b0;

    vecs[0] = '{16'h0008, 16'hF0E1, 16'h0100, 3, 1'b1, 2'd1};
    vecs[1] = '{16'hDD86, 16'hF0E1, 16'h0100, 2, 1'b0, 2'd0};
    vecs[2] = '{16'h0008, 16'hF0E1, 16'h0700, 2, 1'b1, 2'd0};
    vecs[3] = '{16'h0008, 16'hF0E1, 16'h0200, 1, 1'b1, 2'd3};
    vecs[4] = '{16'h0008, 16'hF0E2, 16'h0100, 1, 1'b0, 2'd0};
    vecs[5] = '{16'h0008, 16'hF0E1, 16'h0300, 2, 1'b1, 2'd0};
    vecs[6] = '{16'h0800, 16'hF0E1, 16'h0100, 4, 1'b0, 2'd0};
    vecs[7] = '{16'h0008, 16'hF0E1, 16'h0100, 1, 1'b1, 2'd1};

    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tuser = '0; m_axis_tready = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_index = '0; cfg_wr_valid = 1'b0; cfg_wr_func = '0; cfg_wr_dest = '0;
    obs_beats = 0; obs_dest = '0;
    fork
      monitor();
      ready_driver();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_axis_tvalid === 1'b0, 64'(m_axis_tvalid), 64'd0);
    check("rst_s_ready", s_axis_tready === 1'b0, 64'(s_axis_tready), 64'd0);
    check("rst_m_data", (m_axis_tdata === '0) && (m_axis_tdest === 2'd0) && (m_axis_tlast === 1'b0),
          m_axis_tdata[63:0], 64'd0);
    check("rst_stats", (stat_pass_frames === 32'd0) && (stat_drop_frames === 32'd0),
          {stat_pass_frames, stat_drop_frames}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_edge", s_axis_tready === 1'b0, 64'(s_axis_tready), 64'd0);
    @(posedge clk); #1;
    check("ready_after_edge", s_axis_tready === 1'b1, 64'(s_axis_tready), 64'd1);

    cfg_write(2'd0, 1'b0, 16'h0300, 2'd2);
    cfg_write(2'd1, 1'b1, 16'h0100, 2'd1);
    cfg_write(2'd2, 1'b1, 16'h0200, 2'd3);
    cfg_write(2'd3, 1'b1, 16'h0100, 2'd2);

    // Forwarded 3-beat frame: one-cycle latency, tdest from the lowest hit
    obs_beats = 0;
    b0 = hdr_beat(16'h0008, 16'hF0E1, 16'h0100);
    send_beat(b0, '1, 1'b0, w);
    check("latency1", (m_axis_tvalid === 1'b1) && (m_axis_tdata === b0), m_axis_tdata[63:0], b0[63:0]);
    check("first_dest", m_axis_tdest === 2'd1, 64'(m_axis_tdest), 64'd1);
    send_beat(rand_data(), '1, 1'b0, w);
    send_beat(rand_data(), {$urandom(), $urandom()}, 1'b1, w);
    drain();
    check("first_beats", obs_beats == 3, 64'(obs_beats), 64'd3);
    check("first_pass", stat_pass_frames === exp_stat(1), 64'(stat_pass_frames), 64'(exp_stat(1)));

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      obs_beats = 0;
      send_frame(vecs[v].ether, vecs[v].delim, vecs[v].func, vecs[v].nbeats, w);
      drain();
      check($sformatf("vec%0d_beats", v), obs_beats == (vecs[v].exp_fwd ? vecs[v].nbeats : 0),
            64'(obs_beats), 64'(vecs[v].exp_fwd ? vecs[v].nbeats : 0));
      if (vecs[v].exp_fwd)
        check($sformatf("vec%0d_dest", v), obs_dest === vecs[v].exp_dest,
              64'(obs_dest), 64'(vecs[v].exp_dest));
      else
        check($sformatf("vec%0d_drop_ready", v), w == 0, 64'(w), 64'd0);
      check($sformatf("vec%0d_pass", v), stat_pass_frames === exp_stat(mdl_pass),
            64'(stat_pass_frames), 64'(exp_stat(mdl_pass)));
      check($sformatf("vec%0d_drop", v), stat_drop_frames === exp_stat(mdl_drop),
            64'(stat_drop_frames), 64'(exp_stat(mdl_drop)));
    end

    // 8-beat frame under a 1,0,0,1 output-ready pattern
    rdy_mode = 1;
    obs_beats = 0;
    send_frame(16'h0008, 16'hF0E1, 16'h0200, 8, w);
    drain();
    rdy_mode = 0;
    check("toggle_beats", obs_beats == 8, 64'(obs_beats), 64'd8);
    check("toggle_ready_only_when_full", tready_bad == 0, 64'(tready_bad), 64'd0);
    repeat (2) begin @(posedge clk); #1; end

    // Table write in the same cycle as beat 0: old entry used, new one on the next frame
    obs_beats = 0;
    cfg_wr_index = 2'd1; cfg_wr_valid = 1'b1; cfg_wr_func = 16'h0100; cfg_wr_dest = 2'd2;
    cfg_wr_en = 1'b1;
    send_beat(hdr_beat(16'h0008, 16'hF0E1, 16'h0100), '1, 1'b0, w);
    cfg_wr_en = 1'b0;
    send_beat(rand_data(), '1, 1'b1, w);
    drain();
    check("samecycle_old_dest", obs_dest === 2'd1, 64'(obs_dest), 64'd1);
    send_frame(16'h0008, 16'hF0E1, 16'h0100, 2, w);
    drain();
    check("samecycle_new_dest", obs_dest === 2'd2, 64'(obs_dest), 64'd2);

    // Reset in the middle of a 5-beat forwarded frame
    send_beat(hdr_beat(16'h0008, 16'hF0E1, 16'h0100), '1, 1'b0, w);
    send_beat(rand_data(), '1, 1'b0, w);
    s_axis_tdata = rand_data(); s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_m_valid", m_axis_tvalid === 1'b0, 64'(m_axis_tvalid), 64'd0);
    check("midrst_stats", (stat_pass_frames === 32'd0) && (stat_drop_frames === 32'd0),
          {stat_pass_frames, stat_drop_frames}, 64'd0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    obs_beats = 0;
    send_frame(16'h0008, 16'hF0E1, 16'h0100, 2, w);
    drain();
    check("postrst_beats", obs_beats == 2, 64'(obs_beats), 64'd2);
    check("postrst_table_cleared", obs_dest === 2'd0, 64'(obs_dest), 64'd0);
    check("postrst_pass", stat_pass_frames === exp_stat(1), 64'(stat_pass_frames), 64'(exp_stat(1)));

    // Randomized frames with random output backpressure and occasional table rewrites
    cfg_write(2'd0, 1'b1, 16'h0100, 2'd3);
    cfg_write(2'd1, 1'b1, 16'h0200, 2'd1);
    cfg_write(2'd2, 1'b1, 16'h0100, 2'd2);
    cfg_write(2'd3, 1'b0, 16'h0300, 2'd2);
    rdy_mode = 2;
    for (int f = 0; f < 60; f++) begin
      logic [15:0] eth, dl, fn;
      logic [15:0] funcs [5];
      funcs = '{16'h0100, 16'h0200, 16'h0300, 16'h0700, 16'h0000};
      funcs[4] = 16'($urandom());
      eth = ($urandom_range(0, 3) != 0) ? 16'h0008 : 16'($urandom());
      dl  = ($urandom_range(0, 3) != 0) ? 16'hF0E1 : 16'($urandom());
      fn  = funcs[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0)
        cfg_write(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  funcs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)));
      send_frame(eth, dl, fn, $urandom_range(1, 6), w);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    rdy_mode = 0;
    check("rand_pass", stat_pass_frames === exp_stat(mdl_pass),
          64'(stat_pass_frames), 64'(exp_stat(mdl_pass)));
    check("rand_drop", stat_drop_frames === exp_stat(mdl_drop),
          64'(stat_drop_frames), 64'(exp_stat(mdl_drop)));
    check("rand_ready_only_when_full", tready_bad == 0, 64'(tready_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
